// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: front-end hazard sequencer for the IF/ID buffer and PC.
// It handles three cases:
//   - load-use stalls, which insert a one-cycle bubble;
//   - taken-branch flushes;
//   - a multi-cycle stall while a mult/div op occupies EX.
// Optional macro HAZARD_PERF_CNT_EN enables the stall/flush performance
// counters. When the macro is undefined, both counter ports read zero.
module hazard_stall_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MDU_LATENCY    = 4,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_uses_rt,
    input  logic                      id_is_mdu,
    input  logic                      ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rt,
    input  logic                      branch_taken,
    output logic                      pc_write,
    output logic                      if_id_write,
    output logic                      if_id_flush,
    output logic                      id_ex_bubble,
    output logic                      mdu_busy,
    output logic [CNT_WIDTH-1:0]      stall_cycles,
    output logic [CNT_WIDTH-1:0]      flush_count
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_BUSY = 1'b1
    } state_t;

    // With a single-cycle MDU the op leaves EX on its own and no stall is needed.
    localparam bit         MDU_MULTI = (MDU_LATENCY > 1);
    localparam logic [3:0] CNT_LOAD  = 4'(MDU_LATENCY - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       w_lu;

    // Load-use detection. Register 0 is hardwired, so it never creates a hazard.
    always_comb begin
        w_lu = id_valid && ex_mem_read && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

    // State register and MDU down-counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic and the combinational pipeline-control outputs.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        mdu_busy     = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_lu) begin
                    // The stall wins. A coincident branch is seen again next cycle.
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end else begin
                    if (branch_taken) begin
                        if_id_flush = 1'b1;
                    end
                    // The mult/div op itself advances. The hold begins on the next cycle.
                    if (MDU_MULTI && id_valid && id_is_mdu) begin
                        w_state_next = ST_MDU_BUSY;
                        w_cnt_next   = CNT_LOAD;
                    end
                end
            end
            ST_MDU_BUSY: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                mdu_busy     = 1'b1;
                w_cnt_next   = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
                w_cnt_next   = 4'd0;
            end
        endcase
        // While reset is held, the front end is frozen and flushed regardless of state.
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            mdu_busy     = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_stall_cycles;
    logic [CNT_WIDTH-1:0] r_flush_count;

    // Saturating counters of stalled cycles and flushed cycles outside reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!pc_write && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
            end
            if (if_id_flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + CNT_WIDTH'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard controller that sequences the IF/ID buffer and PC register. Each cycle it decides whether the front end advances, holds, or flushes. It detects load-use hazards and taken-branch redirects, and runs a multi-cycle stall FSM while a mult/div op occupies EX. It sits beside the ID stage and drives `pc_write`, the IF/ID `if_id_write`/`flush` pins, and the ID/EX bubble insert.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 5, register specifier width
- `MDU_LATENCY`, 4, EX-stage cycles of a mult/div op; legal 1..16
- `CNT_WIDTH`, 32, performance counter width

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: rising-edge clock
- `reset` in 1: synchronous, active-high
- `id_valid` in 1: IF/ID holds a real instruction
- `id_rs` in REG_ADDR_WIDTH: ID source register rs
- `id_rt` in REG_ADDR_WIDTH: ID source register rt
- `id_uses_rt` in 1: ID instruction reads rt
- `id_is_mdu` in 1: ID instruction is mult/div
- `ex_mem_read` in 1: ID/EX instruction is a load
- `ex_rt` in REG_ADDR_WIDTH: load destination register
- `branch_taken` in 1: ID-resolved branch/jump redirect
- `pc_write` out 1: PC register enable
- `if_id_write` out 1: IF/ID enable
- `if_id_flush` out 1: IF/ID flush
- `id_ex_bubble` out 1: zero control fields entering ID/EX
- `mdu_busy` out 1: FSM in MDU_BUSY
- `stall_cycles` out CNT_WIDTH: performance counter
- `flush_count` out CNT_WIDTH: performance counter

## Operation
- FSM states: RUN and MDU_BUSY. Down-counter `cnt` is 4 bits.
- Load-use hazard (RUN only): `lu = id_valid & ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt))`.
- Output priority in RUN:
  1. `lu`: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=1.
  2. `branch_taken`: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=0.
  3. Otherwise: pc_write=1, if_id_write=1, flush=0, bubble=0.
- A branch coincident with `lu` is ignored; it is re-evaluated next cycle.
- MDU issue: in RUN with `id_valid & id_is_mdu & !lu` and MDU_LATENCY>1:
  - the op advances normally;
  - next state is MDU_BUSY with cnt=MDU_LATENCY-1.
  - If `branch_taken` is also set, the redirect takes effect as in RUN priority 2.
- MDU_BUSY outputs: pc_write=0, if_id_write=0, flush=0, bubble=1, mdu_busy=1. `branch_taken` is ignored.
- MDU_BUSY transitions: cnt decrements each cycle. When cnt==1, next state is RUN.
- MDU_LATENCY=1: MDU_BUSY is never entered.
- Outputs are combinational from state and inputs. State and cnt are registered.
- Reset: state=RUN, cnt=0, counters=0. While `reset`=1, outputs are forced to pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, mdu_busy=0, overriding any state. Reset asserted in MDU_BUSY aborts the stall; the next non-reset cycle is RUN.

## Timing
- Load-use stall lasts exactly 1 cycle. The following cycle, `ex_mem_read` reflects the bubble.
- Branch flush occurs in the same cycle `branch_taken` is sampled. IF/ID holds the NOP from the next edge.
- MDU: issue at edge T; stall cycles T+1..T+MDU_LATENCY-1; RUN at T+MDU_LATENCY.
- Back-to-back mult/div: the second op issues in the first RUN cycle, costing MDU_LATENCY-1 stall cycles each.
- `mdu_busy` is high exactly while in MDU_BUSY.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cycles` increments on every non-reset cycle with pc_write=0.
  - `flush_count` increments on every non-reset cycle with if_id_flush=1.
  - Both saturate at all-ones and clear on reset.
- Not defined: both counter ports are tied to 0 and no counter flops are synthesized. The port list is unchanged.

## Test plan
- Reset: hold reset 3 cycles with `branch_taken`=1 → pc_write=0, if_id_flush=1, bubble=1, mdu_busy=0 throughout; RUN afterwards.
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 → exactly one cycle of pc_write=0 and bubble=1. Repeat with ex_rt=0 → no stall. Repeat with id_rt=8, id_uses_rt=0 → no stall.
- Branch: branch_taken=1, no hazard → if_id_flush=1, pc_write=1 for one cycle. With a simultaneous load-use → stall only, flush=0.
- MDU, MDU_LATENCY=4: issue mult → mdu_busy high for 3 cycles, then RUN. Two consecutive mults → 6 stall cycles total. Branch during busy → ignored.
- Reset during MDU_BUSY: assert reset at cnt=2 → next non-reset cycle is RUN with mdu_busy=0.
- With HAZARD_PERF_CNT_EN: after the MDU scenario, stall_cycles=3 and flush_count=0. Drive branch_taken on 2 separate cycles → flush_count=2.
